// File: rtl/usb_defs_pkg.sv
// Shared USB receive definitions: PID codes, CRC constants and helpers,
// and the packet decoder state encoding.
package usb_defs_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_DATA2 = 4'h7;
    localparam logic [3:0] PID_MDATA = 4'hF;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_NYET  = 4'h6;

    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic [2:0] {IDLE, TOK, DATA, HSK, DROP} rx_state_e;

    // Bytes arrive LSB first on the wire, so bit 0 is shifted in first.
    function automatic logic [4:0] crc5_update(input logic [4:0] crc, input logic [7:0] data);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[4] ^ data[i]) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[15] ^ data[i]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic pid_is_token(input logic [3:0] p);
        return (p == PID_OUT) || (p == PID_IN) || (p == PID_SOF) || (p == PID_SETUP);
    endfunction

    function automatic logic pid_is_data(input logic [3:0] p);
        return (p == PID_DATA0) || (p == PID_DATA1) || (p == PID_DATA2) || (p == PID_MDATA);
    endfunction

    function automatic logic pid_is_hsk(input logic [3:0] p);
        return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL) || (p == PID_NYET);
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Byte-serial USB CRC16 accumulator; one byte folded in per enabled cycle.
module usb_crc16_byte
    import usb_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    crc_q <= CRC16_INIT;
        else if (init) crc_q <= CRC16_INIT;
        else if (en)   crc_q <= crc16_update(crc_q, data);
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_rx_pkt_decoder.sv
// Receive packet decoder: splits the PHY byte stream into PID/token/payload
// fields, checks PID nibble, CRC5, CRC16 and length, drives host_* outputs.
module usb_rx_pkt_decoder
    import usb_defs_pkg::*;
#(
    parameter int MAX_DATA_LEN = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_error,
    output logic        host_pkt_valid,
    output logic [3:0]  host_pid,
    output logic [6:0]  host_addr,
    output logic [3:0]  host_ep,
    output logic [7:0]  host_data,
    output logic        host_data_valid,
    output logic        host_pkt_end,
    output logic [15:0] host_data_len,
    output logic        host_crc_err
);

    // Byte counter counts bytes after the PID; it saturates so the reported
    // length (count - 2) saturates at MAX_DATA_LEN + 1.
    localparam logic [10:0] CNT_SAT  = 11'(MAX_DATA_LEN + 3);
    localparam logic [10:0] EMIT_LIM = 11'(MAX_DATA_LEN + 2);

    rx_state_e   state_q, state_d;
    logic        armed_q;
    logic [10:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]  pid_q, pid_d;
    logic [6:0]  tok_addr_q, tok_addr_d;
    logic [3:0]  tok_ep_q, tok_ep_d;
    logic [4:0]  crc5_q, crc5_d;
    logic [7:0]  hb0_q, hb0_d, hb1_q, hb1_d;
    logic        crc16_init, crc16_en;
    logic [15:0] crc16;
    logic [15:0] data_len;

    logic        pv_q, pv_d, dv_q, dv_d, end_q, end_d, err_q, err_d;
    logic [3:0]  pido_q, pido_d, ep_q, ep_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  dat_q, dat_d;
    logic [15:0] len_q, len_d;

    usb_crc16_byte u_crc16 (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc16_init),
        .en    (crc16_en),
        .data  (rx_data),
        .crc   (crc16)
    );

    assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 11'd1;
    assign data_len = {5'd0, (cnt_q < 11'd2) ? 11'd0 : cnt_q - 11'd2};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pid_d      = pid_q;
        tok_addr_d = tok_addr_q;
        tok_ep_d   = tok_ep_q;
        crc5_d     = crc5_q;
        hb0_d      = hb0_q;
        hb1_d      = hb1_q;
        crc16_init = 1'b0;
        crc16_en   = 1'b0;
        pv_d       = 1'b0;
        dv_d       = 1'b0;
        end_d      = 1'b0;
        err_d      = err_q;
        pido_d     = pido_q;
        addr_d     = addr_q;
        ep_d       = ep_q;
        dat_d      = dat_q;
        len_d      = len_q;

        case (state_q)
            IDLE: begin
                crc16_init = 1'b1;
                cnt_d      = 11'd0;
                crc5_d     = CRC5_INIT;
                tok_addr_d = 7'd0;
                tok_ep_d   = 4'd0;
                // Until rx_active has been seen low after reset we may be in
                // the middle of someone else's packet, so nothing is a PID.
                if (rx_active && armed_q) begin
                    if (rx_error) begin
                        state_d = DROP;
                    end else if (rx_valid) begin
                        pid_d = rx_data[3:0];
                        if (rx_data[7:4] != ~rx_data[3:0]) state_d = DROP;
                        else if (pid_is_token(rx_data[3:0])) state_d = TOK;
                        else if (pid_is_hsk(rx_data[3:0]))   state_d = HSK;
                        else if (pid_is_data(rx_data[3:0])) begin
                            state_d = DATA;
                            pv_d    = 1'b1;
                            pido_d  = rx_data[3:0];
                            addr_d  = 7'd0;
                            ep_d    = 4'd0;
                            err_d   = 1'b0;
                        end else state_d = DROP;
                    end
                end
            end
            TOK: begin
                if (rx_error || !rx_active) begin
                    pv_d    = 1'b1;
                    pido_d  = pid_q;
                    addr_d  = tok_addr_q;
                    ep_d    = tok_ep_q;
                    err_d   = rx_error || (cnt_q != 11'd2) || (crc5_q != CRC5_RESIDUAL);
                    state_d = rx_error ? DROP : IDLE;
                end else if (rx_valid) begin
                    if (cnt_q == 11'd0) begin
                        tok_addr_d  = rx_data[6:0];
                        tok_ep_d[0] = rx_data[7];
                    end
                    if (cnt_q == 11'd1) tok_ep_d[3:1] = rx_data[2:0];
                    if (cnt_q < 11'd2)  crc5_d = crc5_update(crc5_q, rx_data);
                    cnt_d = cnt_inc;
                end
            end
            HSK: begin
                if (rx_error || !rx_active) begin
                    pv_d    = 1'b1;
                    pido_d  = pid_q;
                    addr_d  = 7'd0;
                    ep_d    = 4'd0;
                    err_d   = rx_error || (cnt_q != 11'd0);
                    state_d = rx_error ? DROP : IDLE;
                end else if (rx_valid) begin
                    cnt_d = cnt_inc;
                end
            end
            DATA: begin
                if (rx_error || !rx_active) begin
                    end_d   = 1'b1;
                    len_d   = data_len;
                    err_d   = rx_error || (crc16 != CRC16_RESIDUAL) ||
                              (cnt_q < 11'd2) || (cnt_q > EMIT_LIM);
                    state_d = rx_error ? DROP : IDLE;
                end else if (rx_valid) begin
                    crc16_en = 1'b1;
                    hb0_d    = rx_data;
                    hb1_d    = hb0_q;
                    cnt_d    = cnt_inc;
                    // The byte leaving the holdback is known payload; the last
                    // two held bytes at EOP are the CRC and never leave.
                    if (cnt_q >= 11'd2 && cnt_q < EMIT_LIM) begin
                        dv_d  = 1'b1;
                        dat_d = hb1_q;
                    end
                end
            end
            DROP: begin
                if (!rx_active) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            cnt_q      <= 11'd0;
            pid_q      <= 4'd0;
            tok_addr_q <= 7'd0;
            tok_ep_q   <= 4'd0;
            crc5_q     <= CRC5_INIT;
            hb0_q      <= 8'd0;
            hb1_q      <= 8'd0;
            pv_q       <= 1'b0;
            dv_q       <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
            pido_q     <= 4'd0;
            addr_q     <= 7'd0;
            ep_q       <= 4'd0;
            dat_q      <= 8'd0;
            len_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_q | ~rx_active;
            cnt_q      <= cnt_d;
            pid_q      <= pid_d;
            tok_addr_q <= tok_addr_d;
            tok_ep_q   <= tok_ep_d;
            crc5_q     <= crc5_d;
            hb0_q      <= hb0_d;
            hb1_q      <= hb1_d;
            pv_q       <= pv_d;
            dv_q       <= dv_d;
            end_q      <= end_d;
            err_q      <= err_d;
            pido_q     <= pido_d;
            addr_q     <= addr_d;
            ep_q       <= ep_d;
            dat_q      <= dat_d;
            len_q      <= len_d;
        end
    end

    assign host_pkt_valid  = pv_q;
    assign host_pid        = pido_q;
    assign host_addr       = addr_q;
    assign host_ep         = ep_q;
    assign host_data       = dat_q;
    assign host_data_valid = dv_q;
    assign host_pkt_end    = end_q;
    assign host_data_len   = len_q;
    assign host_crc_err    = err_q;

endmodule

// File: doc/usb_rx_pkt_decoder.md
# usb_rx_pkt_decoder

Receive-side packet decoder between the byte-level PHY/SIE receiver and `usb_top`. It turns the SYNC-stripped, EOP-framed byte stream into decoded packet fields: PID, address, endpoint, payload bytes and length. It checks the PID check nibble, token CRC5, data CRC16 and packet length, and drives `usb_top`'s `host_*` receive interface directly.

## Interface
- `MAX_DATA_LEN`, default 1023: largest accepted payload in bytes, CRC excluded.
- `clk  in  1`: single clock; everything is on rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `rx_active  in  1`: high from the first byte (PID) to EOP.
- `rx_valid  in  1`: `rx_data` is valid this cycle; only meaningful while `rx_active` is high.
- `rx_data  in  8`: received byte, LSB first on the wire.
- `rx_error  in  1`: PHY error (bit-stuff or framing); aborts the packet.
- `host_pkt_valid  out  1`: one-cycle pulse, packet header decoded.
- `host_pid  out  4`: PID, held until the next `host_pkt_valid`.
- `host_addr  out  7`: token address; 0 for non-token packets.
- `host_ep  out  4`: token endpoint; 0 for non-token packets.
- `host_data  out  8`: payload byte.
- `host_data_valid  out  1`: `host_data` is valid this cycle.
- `host_pkt_end  out  1`: one-cycle pulse, end of a DATA packet.
- `host_data_len  out  16`: payload length; valid with `host_pkt_end`.
- `host_crc_err  out  1`: packet is bad; valid with `host_pkt_valid` (token/handshake) or `host_pkt_end` (data).

## Operation
- FSM states: `IDLE`, `TOK`, `DATA`, `HSK`, `DROP`.
- `IDLE`: the first `rx_valid` byte is the PID byte. The check `rx_data[7:4] == ~rx_data[3:0]` must hold; on failure go to `DROP`. Otherwise branch on PID type:
  - token (OUT, IN, SETUP, SOF) → `TOK`
  - DATA0/1/2, MDATA → `DATA`
  - handshake → `HSK`
- `TOK`: capture exactly 2 more bytes.
  - Field layout: `addr = b1[6:0]`, `ep = {b2[2:0], b1[7]}`, `crc5 = b2[7:3]`.
  - CRC5 is x^5+x^2+1, init 5'h1F, over the 11 bits plus the received CRC; the residual must equal 5'b01100.
  - When `rx_active` falls, pulse `host_pkt_valid`. `host_crc_err` is set if the byte count ≠ 3 or the residual is wrong.
- `HSK`: when `rx_active` falls, pulse `host_pkt_valid`. `host_crc_err` is set if the byte count ≠ 1. `addr` and `ep` read 0.
- `DATA`:
  - Pulse `host_pkt_valid` the cycle after the PID byte.
  - The last 2 bytes are CRC, so keep a 2-byte holdback: byte k appears on `host_data` the cycle after byte k+2 is accepted. CRC bytes are never emitted.
  - CRC16 is x^16+x^15+x^2+1, init 16'hFFFF, over payload plus CRC; the residual must equal 16'h800D.
  - When `rx_active` falls, pulse `host_pkt_end` with `host_data_len` = bytes received − 2.
  - `host_crc_err` is set on bad residual, fewer than 2 bytes after the PID, or length > `MAX_DATA_LEN`. Once the limit is exceeded, stop emitting payload bytes.
- `DROP`: ignore everything until `rx_active` is low, then return to `IDLE`. A PID-check failure produces no output at all.
- `rx_error` in any non-`IDLE` state:
  - In `DATA`: pulse `host_pkt_end` with `host_crc_err=1`, then go to `DROP`.
  - In `TOK`/`HSK`: pulse `host_pkt_valid` with `host_crc_err=1`, then go to `DROP`.
- `rx_valid` without `rx_active` is ignored.

## Timing
- All outputs are registered.
- Reset values: all outputs 0; FSM in `IDLE`; holdback empty; CRC registers at their init values.
- Token/handshake `host_pkt_valid`: 1 cycle after the cycle `rx_active` is sampled low.
- DATA `host_pkt_valid`: 1 cycle after the PID byte is accepted.
- DATA `host_pkt_end`: 1 cycle after `rx_active` is sampled low. It never coincides with `host_data_valid`.
- No back-pressure; `rx_valid` may assert every cycle.
- A new packet's `rx_active` rise is accepted in the cycle after the previous `host_pkt_end` / `host_pkt_valid`.
- `host_data_len` saturates at `MAX_DATA_LEN+1`; the counter is 11 bits, zero-extended to 16.
- Reset mid-packet: outputs clear immediately and no end pulse is emitted. The remaining bytes of the interrupted packet are dropped until `rx_active` is low.

## Structure
- `usb_defs_pkg` holds:
  - PID constants (`PID_SETUP` = 4'hD, `PID_OUT`, `PID_IN`, `PID_SOF`, `PID_DATA0`/`1`/`2`, `PID_MDATA`, `PID_ACK`, `PID_NAK`, `PID_STALL`, `PID_NYET`);
  - residual constants `CRC5_RESIDUAL` and `CRC16_RESIDUAL`;
  - function `crc5_update`;
  - PID-class helper functions.
- One sub-module, `usb_crc16_byte`: byte-serial CRC16 with `init`/`en`/`data` inputs and a `crc` output, one byte per cycle.

## Test plan
- SETUP token bytes 2D 00 10 → one `host_pkt_valid` with `host_pid`=4'hD, `host_addr`=0, `host_ep`=0, `host_crc_err`=0.
- DATA0 C3 + SET_ADDRESS payload 00 05 05 00 00 00 00 00 + bench-computed CRC16 → `host_pkt_valid` with pid 4'h3; exactly 8 `host_data_valid` beats in order; `host_pkt_end` with `host_data_len`=8 and `host_crc_err`=0. Flipping payload byte 2 to 04 → same beats, `host_crc_err`=1.
- ACK D2 → `host_pkt_valid` with pid 4'h2 and no error. Byte 2C (check nibble fails) → no output pulse at all.
- Token 2D 00 (short) → `host_pkt_valid` with `host_crc_err`=1. Token 2D 00 11 (bad CRC5) → `host_crc_err`=1.
- DATA1 with `rx_error` after 4 payload bytes → `host_pkt_end` with `host_crc_err`=1. A following valid IN token 69 00 10 decodes cleanly.
- `rst_n` pulsed low mid-DATA → all outputs 0 and no `host_pkt_end`. The next packet decodes correctly. Back-to-back packets with 1 idle cycle both decode.
